serializer: RTL



---
 rtl/serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/serializer.sv
// Word-to-bit serializer: dequeues 8-bit words from the word queue and shifts
// each one out as a 1-bit stream under a valid/stall handshake.
module serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  output logic       deq_out,
  input  logic       stall_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [7:0] sent_count_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CAPTURE,
    S_SHIFT
  } state_t;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;

  logic       w_first_bit;
  logic       w_next_bit;
  logic [7:0] w_shift_next;
  logic       w_last_bit;
  logic       w_len_nz;

  // The head of the shift register is always the bit currently on data_out.
  assign w_first_bit  = MSB_FIRST ? data_in[7] : data_in[0];
  assign w_next_bit   = MSB_FIRST ? r_shift[6] : r_shift[1];
  assign w_shift_next = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
  assign w_last_bit   = (r_bit_cnt == 3'd7);
  assign w_len_nz     = (len_in != 8'd0);

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_shift        <= 8'd0;
      r_bit_cnt      <= 3'd0;
      deq_out        <= 1'b0;
      data_out       <= 1'b0;
      write_out      <= 1'b0;
      busy_out       <= 1'b0;
      sent_count_out <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          data_out  <= 1'b0;
          write_out <= 1'b0;
          if (w_len_nz) begin
            r_state  <= S_REQ;
            deq_out  <= 1'b1;
            busy_out <= 1'b1;
          end else begin
            deq_out  <= 1'b0;
            busy_out <= 1'b0;
          end
        end

        S_REQ: begin
          deq_out <= 1'b0;
          r_state <= S_CAPTURE;
        end

        // The queue presents the dequeued word during this cycle.
        S_CAPTURE: begin
          r_shift   <= data_in;
          r_bit_cnt <= 3'd0;
          data_out  <= w_first_bit;
          write_out <= 1'b1;
          r_state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (!stall_in) begin
            if (w_last_bit) begin
              sent_count_out <= sent_count_out + 8'd1;
              data_out       <= 1'b0;
              write_out      <= 1'b0;
              if (w_len_nz) begin
                r_state <= S_REQ;
                deq_out <= 1'b1;
              end else begin
                r_state  <= S_IDLE;
                busy_out <= 1'b0;
              end
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              data_out  <= w_next_bit;
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          deq_out   <= 1'b0;
          data_out  <= 1'b0;
          write_out <= 1'b0;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule
